// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: op encoding, default
// address width, the empty-stack pointer value and the op decoder.
package mem_pkg;

  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] SP_EMPTY = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    LOAD    = 3'd1,
    STORE   = 3'd2,
    PUSH    = 3'd3,
    POP     = 3'd4,
    ILLEGAL = 3'd5
  } mem_op_t;

  // More than one select high collapses to ILLEGAL.
  function automatic mem_op_t decode_op(input logic rd, input logic wr,
                                        input logic pu, input logic po);
    mem_op_t op;
    case ({rd, wr, pu, po})
      4'b0000: op = NONE;
      4'b1000: op = LOAD;
      4'b0100: op = STORE;
      4'b0010: op = PUSH;
      4'b0001: op = POP;
      default: op = ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Data memory: 1R1W 16-bit RAM, synchronous write, combinational read, no reset.
// The read is combinational so the stage's MEM/WB register captures it directly.
module data_memory #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: loads/stores, hardware stack push/pop, MEM/WB register
// and load forwarding back to the ALU stage.
module memory_stage
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = mem_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       store_data,
  input  logic [2:0]        rd,
  input  logic              wb,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  output logic              out_valid,
  output logic              wb_en,
  output logic [2:0]        wb_rd,
  output logic [15:0]       wb_data,
  output logic [15:0]       load_fwd,
  output logic              load_fwd_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_fault
);

  localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] SP_ZERO = {ADDR_W{1'b0}};

  mem_op_t           w_op;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_sp_inc;
  logic              w_full;
  logic              w_empty;
  logic              w_suppress;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [15:0]       w_rdata;
  logic [15:0]       w_next_data;

  logic              r_valid;
  logic              r_wb_en;
  logic [2:0]        r_wb_rd;
  logic [15:0]       r_wb_data;
  logic              r_is_load;
  logic [ADDR_W-1:0] r_sp;
  logic              r_fault;

  assign w_op     = decode_op(mem_read, mem_write, push, pop);
  assign w_addr   = alu_result[ADDR_W-1:0];
  assign w_sp_inc = r_sp + SP_ONE;
  assign w_full   = (r_sp == SP_ZERO);
  assign w_empty  = (r_sp == SP_RESET);

  assign w_suppress = (w_op == ILLEGAL) ||
                      ((w_op == PUSH) && w_full) ||
                      ((w_op == POP) && w_empty);
  assign w_push_ok  = in_valid && (w_op == PUSH) && !w_full;
  assign w_pop_ok   = in_valid && (w_op == POP) && !w_empty;

  // rst_n gates the write so no edge during reset can commit data.
  assign w_we    = rst_n && ((in_valid && (w_op == STORE)) || w_push_ok);
  assign w_waddr = (w_op == PUSH) ? r_sp : w_addr;
  assign w_raddr = (w_op == POP) ? w_sp_inc : w_addr;

  data_memory #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_data_memory (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (store_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Write-back data selection per op.
  always_comb begin
    w_next_data = alu_result;
    case (w_op)
      LOAD:    w_next_data = w_rdata;
      POP:     w_next_data = w_empty ? 16'h0000 : w_rdata;
      default: w_next_data = alu_result;
    endcase
  end

  // MEM/WB register, stack pointer and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= 3'd0;
      r_wb_data <= 16'h0000;
      r_is_load <= 1'b0;
      r_sp      <= SP_RESET;
      r_fault   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_wb_en   <= wb && !w_suppress && (w_op != STORE) && (w_op != PUSH);
        r_wb_rd   <= rd;
        r_wb_data <= w_next_data;
        r_is_load <= (w_op == LOAD) || w_pop_ok;
        if (w_suppress) begin
          r_fault <= 1'b1;
        end
      end else begin
        r_wb_en   <= 1'b0;
        r_is_load <= 1'b0;
      end
      if (w_push_ok) begin
        r_sp <= r_sp - SP_ONE;
      end else if (w_pop_ok) begin
        r_sp <= w_sp_inc;
      end
    end
  end

  assign out_valid      = r_valid;
  assign wb_en          = r_wb_en;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign load_fwd       = r_is_load ? r_wb_data : 16'h0000;
  assign load_fwd_valid = r_is_load && r_wb_en;
  assign sp             = r_sp;
  assign stack_fault    = r_fault;

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the ALU stage. It consumes the buffered ALU result as a data address, the store operand, and the decoded memory-control bits. It performs data-memory loads and stores and push/pop on a hardware stack. Results are registered into the MEM/WB buffer that feeds register write-back, and the load result is also forwarded back to the ALU stage for the load-use case.

## Interface
- `ADDR_W`, 10: data-memory address width; depth = 2**ADDR_W 16-bit words.
- `SP_RESET`, 2**ADDR_W-1: stack-pointer reset value; this value means "stack empty".
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present in this slot; 0 = bubble.
- `alu_result`  in  16  ALU output: load/store address, or pass-through write-back data.
- `store_data`  in  16  operand written by store/push.
- `rd`  in  3  destination register.
- `wb`  in  1  instruction writes a register.
- `mem_read`, `mem_write`, `push`, `pop`  in  1 each  memory op select; one-hot or all zero.
- `out_valid`  out  1  MEM/WB slot valid.
- `wb_en`  out  1  register-file write enable.
- `wb_rd`  out  3  destination register.
- `wb_data`  out  16  write-back data.
- `load_fwd`  out  16  combinational copy of `wb_data` when the MEM/WB slot holds a load or pop, else 0.
- `load_fwd_valid`  out  1  MEM/WB slot holds a valid load or pop with `wb_en`.
- `sp`  out  ADDR_W  current stack pointer; points to the next free slot.
- `stack_fault`  out  1  sticky fault flag; cleared only by reset.

## Operation
- Address = `alu_result[ADDR_W-1:0]`; upper bits ignored.
- Accepted op (in_valid=1, exactly one select high, or none):
  - none: `wb_data` <= alu_result.
  - mem_read: `wb_data` <= mem[addr].
  - mem_write: mem[addr] <= store_data; wb_en forced 0.
  - push: mem[sp] <= store_data; sp <= sp-1; wb_en forced 0.
  - pop: wb_data <= mem[sp+1]; sp <= sp+1.
- Stack capacity is 2**ADDR_W-1. Address 0 is never used by the stack.
- Push with sp==0 (full): suppressed, no write, sp holds, stack_fault <= 1.
- Pop with sp==SP_RESET (empty): suppressed, sp holds, wb_data <= 0, wb_en <= 0, stack_fault <= 1.
- Select not one-hot (two or more high): entire op is a NOP, wb_en <= 0, no write, stack_fault <= 1; out_valid still 1.
- in_valid=0: no memory write, sp holds, out_valid <= 0, wb_en <= 0; wb_data and wb_rd hold.
- wb_en <= in_valid & wb & (op not suppressed) & !(mem_write|push).
- sp arithmetic is ADDR_W bits; the guards above make wrap-around unreachable.

## Timing
- Latency is 1 cycle: inputs sampled at posedge N appear on the MEM/WB outputs after posedge N. The memory write also completes at posedge N.
- Read-after-write to the same address in consecutive cycles returns the new data; the memory is write-first across cycles.
- Back-to-back push then pop returns the pushed value in the following cycle.
- No stall or backpressure; one instruction accepted every cycle.
- Reset values: out_valid 0, wb_en 0, wb_rd 0, wb_data 0, load_fwd 0, load_fwd_valid 0, sp SP_RESET, stack_fault 0. Memory contents are not reset.
- Asserting rst_n low mid-operation clears all registers immediately. No write is committed at any edge where rst_n is low.

## Structure
- Shared package `mem_pkg`: `mem_op_t` enum (NONE, LOAD, STORE, PUSH, POP, ILLEGAL), the default `ADDR_W`, and the `SP_EMPTY` constant.
- Sub-module `data_memory`: synchronous 1R1W 16-bit RAM with write enable, no reset. The stage owns the op decode, stack pointer, fault flag and MEM/WB register.

## Test plan
- After reset, one-hot checks: sp=0x3FF; store 0xBEEF to addr 5, then load addr 5 → next cycle wb_data=0xBEEF, wb_en=1, load_fwd=0xBEEF, load_fwd_valid=1.
- Push 0x1111, push 0x2222, pop, pop → sp sequence 0x3FE, 0x3FD, 0x3FE, 0x3FF; pop data 0x2222 then 0x1111.
- Pop on empty stack → wb_en=0, wb_data=0, sp=0x3FF, stack_fault=1 and stays 1 until rst_n low.
- Push with sp forced to 0 via 1023 pushes → the 1024th push writes nothing, sp=0, stack_fault=1.
- mem_read and mem_write both high with in_valid=1 → no write (the addressed word keeps its old value), wb_en=0, out_valid=1, stack_fault=1. in_valid=0 with mem_write=1 → no write, out_valid=0.
- Assert rst_n low during a push cycle → sp returns to 0x3FF, all outputs 0, and the target word is unchanged.
